// File: rtl/writeback_regfile.sv
// Y86-64 SEQ register file and write-back stage: operand reads, destination
// decode (with cmov squash), commit and the halt/error status machine.
module writeback_regfile #(
  parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        mem_error,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [2:0]  stat,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_AOK = 3'd1,
    ST_HLT = 3'd2,
    ST_ADR = 3'd3,
    ST_INS = 3'd4
  } state_t;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  state_t      state;
  logic [63:0] regs [15];
  logic [3:0]  src_a;
  logic [3:0]  src_b;

  always_comb begin
    src_a = REG_NONE;
    src_b = REG_NONE;
    dstE  = REG_NONE;
    dstM  = REG_NONE;
    case (icode)
      4'h2: begin
        src_a = rA;
        dstE  = cnd ? rB : REG_NONE;
      end
      4'h3: dstE = rB;
      4'h4: begin
        src_a = rA;
        src_b = rB;
      end
      4'h5: begin
        src_b = rB;
        dstM  = rA;
      end
      4'h6: begin
        src_a = rA;
        src_b = rB;
        dstE  = rB;
      end
      4'h8: begin
        src_b = REG_RSP;
        dstE  = REG_RSP;
      end
      4'h9, 4'hB: begin
        src_a = REG_RSP;
        src_b = REG_RSP;
        dstE  = REG_RSP;
        dstM  = (icode == 4'hB) ? rA : REG_NONE;
      end
      4'hA: begin
        src_a = rA;
        src_b = REG_RSP;
        dstE  = REG_RSP;
      end
      default: ;
    endcase
  end

  // Reads see pre-edge state only; there is no same-edge write bypass.
  assign valA   = (src_a == REG_NONE) ? '0 : regs[src_a];
  assign valB   = (src_b == REG_NONE) ? '0 : regs[src_b];
  assign stat   = state;
  assign halted = (state != ST_AOK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_AOK;
      for (int unsigned i = 0; i < 15; i++)
        regs[i] <= (i == 4) ? STACK_INIT : '0;
    end else if (wb_en && state == ST_AOK) begin
      if (mem_error)
        state <= ST_ADR;
      else if (icode > 4'hB)
        state <= ST_INS;
      else if (icode == 4'h0)
        state <= ST_HLT;
      else begin
        // dstM is checked first so valM wins when both target one register.
        for (int unsigned i = 0; i < 15; i++) begin
          if (dstM == 4'(i))
            regs[i] <= valM;
          else if (dstE == 4'(i))
            regs[i] <= valE;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized scoreboard bench for writeback_regfile against an array-based
// architectural model of the Y86-64 register file and status rules.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_en = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic [3:0]  rA = 4'hF;
  logic [3:0]  rB = 4'hF;
  logic        cnd = 1'b0;
  logic [63:0] valE = '0;
  logic [63:0] valM = '0;
  logic        mem_error = 1'b0;
  logic [63:0] valA, valB;
  logic [3:0]  dstE, dstM;
  logic [2:0]  stat;
  logic        halted;

  writeback_regfile #(.STACK_INIT(64'h200)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .mem_error(mem_error),
    .valA(valA), .valB(valB), .dstE(dstE), .dstM(dstM),
    .stat(stat), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  de;
    logic [3:0]  dm;
    logic [2:0]  st;
    logic        h;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] m_regs [16];
  int          m_stat = 0;
  bit          m_valid = 1'b0;

  function automatic logic [63:0] rd(input logic [3:0] r);
    return (r == 4'hF) ? 64'd0 : m_regs[r];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Drive one cycle of inputs, queue what the DUT must show before the edge,
  // then advance the architectural model across that edge.
  task automatic drive(input bit r, input bit en, input logic [3:0] ic,
                       input logic [3:0] ra, input logic [3:0] rb, input bit c,
                       input logic [63:0] ve, input logic [63:0] vm, input bit me);
    exp_t e;
    logic [3:0] sa, sbr, de, dm;
    @(posedge clk);
    #1;
    rst = r; wb_en = en; icode = ic; rA = ra; rB = rb; cnd = c;
    valE = ve; valM = vm; mem_error = me;
    sa = 4'hF; sbr = 4'hF; de = 4'hF; dm = 4'hF;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = ra;
    if (ic inside {4'h9, 4'hB}) sa = 4'h4;
    if (ic inside {4'h4, 4'h5, 4'h6}) sbr = rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) sbr = 4'h4;
    if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) de = rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'h4;
    if (ic == 4'h5 || ic == 4'hB) dm = ra;
    if (m_valid) begin
      e.a = rd(sa); e.b = rd(sbr); e.de = de; e.dm = dm;
      e.st = 3'(m_stat); e.h = (m_stat != 1);
      sb.push_back(e);
    end
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 64'd0;
      m_regs[4] = 64'h200;
      m_stat = 1;
      m_valid = 1'b1;
    end else if (en && m_stat == 1) begin
      if (me) m_stat = 3;
      else if (ic > 4'hB) m_stat = 4;
      else if (ic == 4'h0) m_stat = 2;
      else begin
        if (de != 4'hF) m_regs[de] = ve;
        if (dm != 4'hF) m_regs[dm] = vm;
      end
    end
  endtask

  // Read-only probe: OPq sources rA/rB without any write because wb_en is low.
  task automatic probe(input logic [3:0] ra, input logic [3:0] rb);
    drive(0, 0, 4'h6, ra, rb, 0, '0, '0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("valA", valA, e.a);
        check("valB", valB, e.b);
        check("dstE", 64'(dstE), 64'(e.de));
        check("dstM", 64'(dstM), 64'(e.dm));
        check("stat", 64'(stat), 64'(e.st));
        check("halted", 64'(halted), 64'(e.h));
      end
    end
  end

  initial begin : stimulus
    logic [3:0] ic;
    drive(1, 0, 4'h1, 4'hF, 4'hF, 0, '0, '0, 0);
    for (int i = 0; i < 15; i += 2) probe(4'(i), 4'(i + 1));
    probe(4'hF, 4'h4);
    // irmovq then OPq reading r3, during and after the write
    drive(0, 1, 4'h3, 4'hF, 4'h3, 0, 64'h1234, '0, 0);
    drive(0, 1, 4'h6, 4'h3, 4'h1, 0, 64'h77, '0, 0);
    probe(4'h3, 4'h1);
    // cmov squashed then taken
    drive(0, 1, 4'h2, 4'h1, 4'h2, 0, 64'hAA, '0, 0);
    probe(4'h2, 4'h2);
    drive(0, 1, 4'h2, 4'h1, 4'h2, 1, 64'hAA, '0, 0);
    probe(4'h2, 4'h2);
    // popq %rsp then pushq %r5
    drive(0, 1, 4'hB, 4'h4, 4'hF, 0, 64'h208, 64'h55, 0);
    probe(4'h4, 4'h5);
    drive(0, 1, 4'h3, 4'hF, 4'h5, 0, 64'h5555, '0, 0);
    drive(0, 1, 4'hA, 4'h5, 4'hF, 0, 64'h4D, '0, 0);
    probe(4'h4, 4'h5);
    // halt absorbs, rst recovers
    drive(0, 1, 4'h0, 4'hF, 4'hF, 0, '0, '0, 0);
    drive(0, 1, 4'h3, 4'hF, 4'h1, 0, 64'h99, '0, 0);
    probe(4'h1, 4'h1);
    drive(1, 1, 4'h3, 4'hF, 4'h1, 0, 64'h99, '0, 0);
    probe(4'h1, 4'h4);
    // error priority
    drive(0, 1, 4'hE, 4'hF, 4'h1, 0, 64'h11, '0, 1);
    probe(4'h1, 4'h1);
    drive(1, 0, 4'h1, 4'hF, 4'hF, 0, '0, '0, 0);
    drive(0, 1, 4'hD, 4'hF, 4'h1, 0, 64'h11, '0, 0);
    drive(0, 1, 4'hD, 4'hF, 4'h1, 0, 64'h11, '0, 0);
    drive(1, 1, 4'hD, 4'hF, 4'h1, 0, 64'h11, '0, 0);
    drive(0, 1, 4'h0, 4'hF, 4'hF, 0, '0, '0, 1);
    drive(1, 0, 4'h1, 4'hF, 4'hF, 0, '0, '0, 0);
    // randomized traffic, mostly valid instructions in RUN
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) < 92) ic = 4'($urandom_range(11, 1));
      else ic = 4'($urandom_range(15));
      drive($urandom_range(99) < 3, $urandom_range(99) < 85, ic,
            4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
            {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(99) < 2);
    end
    drive(0, 0, 4'h1, 4'hF, 4'hF, 0, '0, '0, 0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
